// File: rtl/alu_seq_pkg.sv
// Shared encodings and default widths for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int RES_W  = 16;
  localparam int CNT_W  = 4;

  localparam logic [2:0] SWEEP_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter; done is high during the last counted cycle (count == 1).
module alu_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives registered operands/select into an 8-bit ALU, captures y after a settle
// time and hands it downstream; sweep mode walks sel 0..7 on the held operands.
module alu_op_sequencer #(
  parameter int DATA_W = alu_seq_pkg::DATA_W,
  parameter int SEL_W  = alu_seq_pkg::SEL_W,
  parameter int RES_W  = alu_seq_pkg::RES_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              sweep_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_y,
  output logic [SEL_W-1:0]  res_sel,
  output logic              busy,
  output logic              sweep_done
);

  import alu_seq_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [RES_W-1:0]  res_y_q, res_y_d;
  logic [SEL_W-1:0]  res_sel_q, res_sel_d;
  logic              res_valid_q, res_valid_d;
  logic              sweep_q, sweep_d;
  logic              sweep_done_q, sweep_done_d;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_done;

  alu_settle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(CNT_W'(SETTLE)),
    .dec     (tmr_dec),
    .done    (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    res_y_d      = res_y_q;
    res_sel_d    = res_sel_q;
    res_valid_d  = res_valid_q;
    sweep_d      = sweep_q;
    sweep_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        // A command takes priority over a simultaneous sweep request.
        if (cmd_valid) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_sel;
          tmr_load  = 1'b1;
          state_d   = WAIT;
        end else if (sweep_start) begin
          alu_sel_d = '0;
          sweep_d   = 1'b1;
          tmr_load  = 1'b1;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          res_y_d     = alu_y;
          res_sel_d   = alu_sel_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (sweep_q && (alu_sel_q != SEL_W'(SWEEP_LAST))) begin
            alu_sel_d = alu_sel_q + SEL_W'(1);
            tmr_load  = 1'b1;
            state_d   = WAIT;
          end else begin
            sweep_done_d = sweep_q;
            sweep_d      = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      res_y_q      <= '0;
      res_sel_q    <= '0;
      res_valid_q  <= 1'b0;
      sweep_q      <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      res_y_q      <= res_y_d;
      res_sel_q    <= res_sel_d;
      res_valid_q  <= res_valid_d;
      sweep_q      <= sweep_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Ready is held low during reset so nothing is offered as accepted.
  assign cmd_ready  = rst_n && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign res_valid  = res_valid_q;
  assign res_y      = res_y_q;
  assign res_sel    = res_sel_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus randomized traffic against
// a transaction-level model; a SETTLE=3 instance covers the longer settle path.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_sel = '0;
  logic        sweep_start = 1'b0;
  logic        res_ready = 1'b0;

  logic        cmd_ready, res_valid, busy, sweep_done;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_sel, res_sel;
  logic [15:0] alu_y, res_y;

  logic        cmd_ready3, res_valid3, busy3, sweep_done3;
  logic [7:0]  alu_a3, alu_b3;
  logic [2:0]  alu_sel3, res_sel3;
  logic [15:0] alu_y3, res_y3;
  logic        glitch = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign alu_y  = {5'b0, alu_sel, alu_a ^ alu_b};
  assign alu_y3 = glitch ? 16'hDEAD : {5'b0, alu_sel3, alu_a3 ^ alu_b3};

  alu_op_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .sweep_start(sweep_start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_sel(res_sel),
    .busy(busy), .sweep_done(sweep_done)
  );

  alu_op_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .sweep_start(sweep_start),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_y(alu_y3),
    .res_valid(res_valid3), .res_ready(res_ready), .res_y(res_y3), .res_sel(res_sel3),
    .busy(busy3), .sweep_done(sweep_done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    total++; if ({alu_a, alu_b, alu_sel} !== 19'h0) begin bad++; $display("FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_sel}); end
    total++; if ({res_y, res_sel} !== 19'h0) begin bad++; $display("FAIL reset_res_regs: got %h want 0", {res_y, res_sel}); end
    total++; if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sweep_done: got %b want 0", sweep_done); end
    total++; if (cmd_ready3 !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready3: got %b want 0", cmd_ready3); end
    rst_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_op();
    res_ready = 1'b1;
    cmd_a = 8'h85; cmd_b = 8'hC2; cmd_sel = 3'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    total++; if ({alu_a, alu_b, alu_sel} !== {8'h85, 8'hC2, 3'd3}) begin bad++; $display("FAIL single_alu_drive: got %h want %h", {alu_a, alu_b, alu_sel}, {8'h85, 8'hC2, 3'd3}); end
    total++; if (res_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL single_wait_flags: got v=%b busy=%b rdy=%b want 0 1 0", res_valid, busy, cmd_ready); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
    total++; if (res_y !== 16'h0347 || res_sel !== 3'd3) begin bad++; $display("FAIL single_result: got %h/%0d want 0347/3", res_y, res_sel); end
    step();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL single_back_idle: got v=%b busy=%b rdy=%b want 0 0 1", res_valid, busy, cmd_ready); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    cmd_a = 8'h85; cmd_b = 8'hC2; cmd_sel = 3'd3; cmd_valid = 1'b1;
    step();
    // A second command held while busy must not be taken.
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_sel = 3'd1;
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1 || res_y !== 16'h0347) begin bad++; $display("FAIL bp_hold_%0d: got v=%b y=%h want 1 0347", i, res_valid, res_y); end
      total++; if (cmd_ready !== 1'b0 || alu_a !== 8'h85) begin bad++; $display("FAIL bp_no_accept_%0d: got rdy=%b a=%h want 0 85", i, cmd_ready, alu_a); end
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_before_release: got %b want 1", res_valid); end
    step();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", res_valid, busy); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_single_handshake: got %b want 0", res_valid); end
  endtask

  task automatic test_sweep();
    int n = 0;
    int done_cnt = 0;
    int done_edge = -1;
    logic [2:0] nsel;
    res_ready = 1'b1;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    total++; if (alu_sel !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL sweep_start: got sel=%0d busy=%b want 0 1", alu_sel, busy); end
    for (int c = 1; c <= 24; c++) begin
      step();
      if (sweep_done === 1'b1) begin done_cnt++; done_edge = c; end
      if (res_valid === 1'b1) begin
        nsel = n[2:0];
        total++; if (res_sel !== nsel || res_y !== {5'b0, nsel, 8'h47}) begin bad++; $display("FAIL sweep_result_%0d: got %0d/%h want %0d/%h", n, res_sel, res_y, nsel, {5'b0, nsel, 8'h47}); end
        n++;
      end
      if (c == 16) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sweep_duration: got busy=%b want 0 at 16 cycles", busy); end
      end
    end
    total++; if (n != 8) begin bad++; $display("FAIL sweep_count: got %0d want 8", n); end
    total++; if (done_cnt != 1 || done_edge != 16) begin bad++; $display("FAIL sweep_done_pulse: got count=%0d at %0d want 1 at 16", done_cnt, done_edge); end
  endtask

  task automatic test_simultaneous();
    int results = 0;
    int dones = 0;
    res_ready = 1'b1;
    cmd_a = 8'h01; cmd_b = 8'h02; cmd_sel = 3'd5; cmd_valid = 1'b1; sweep_start = 1'b1;
    step();
    cmd_valid = 1'b0; sweep_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (sweep_done === 1'b1) dones++;
      if (res_valid === 1'b1) begin
        results++;
        total++; if (res_y !== 16'h0503 || res_sel !== 3'd5) begin bad++; $display("FAIL simul_result: got %h/%0d want 0503/5", res_y, res_sel); end
      end
    end
    total++; if (results != 1 || dones != 0) begin bad++; $display("FAIL simul_no_sweep: got results=%0d dones=%0d want 1 0", results, dones); end
    total++; if (alu_sel !== 3'd5 || busy !== 1'b0) begin bad++; $display("FAIL simul_end_state: got sel=%0d busy=%b want 5 0", alu_sel, busy); end
  endtask

  task automatic test_reset_mid_sweep();
    int results = 0;
    int dones = 0;
    res_ready = 1'b1;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int c = 0; c < 6; c++) step();
    total++; if (alu_sel !== 3'd3 || busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL rst_sweep_4th_wait: got sel=%0d busy=%b v=%b want 3 1 0", alu_sel, busy, res_valid); end
    rst_n = 1'b0;
    step();
    total++; if ({alu_a, alu_b, alu_sel, res_y, res_sel} !== 38'h0) begin bad++; $display("FAIL rst_sweep_regs: got %h want 0", {alu_a, alu_b, alu_sel, res_y, res_sel}); end
    total++; if ({res_valid, sweep_done, busy, cmd_ready} !== 4'b0) begin bad++; $display("FAIL rst_sweep_flags: got %b want 0000", {res_valid, sweep_done, busy, cmd_ready}); end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (res_valid === 1'b1 || res_valid3 === 1'b1) results++;
      if (sweep_done === 1'b1 || sweep_done3 === 1'b1) dones++;
    end
    total++; if (results != 0 || dones != 0) begin bad++; $display("FAIL rst_sweep_quiet: got results=%0d dones=%0d want 0 0", results, dones); end
  endtask

  task automatic test_settle3();
    logic [7:0] a, b;
    logic [2:0] s;
    a = 8'($urandom); b = 8'($urandom); s = 3'($urandom);
    res_ready = 1'b1;
    total++; if (cmd_ready3 !== 1'b1 || busy3 !== 1'b0) begin bad++; $display("FAIL s3_idle: got rdy=%b busy=%b want 1 0", cmd_ready3, busy3); end
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    glitch = 1'b1;
    total++; if (alu_a3 !== a || res_valid3 !== 1'b0) begin bad++; $display("FAIL s3_accept: got a=%h v=%b want %h 0", alu_a3, res_valid3, a); end
    step();
    glitch = 1'b0;
    total++; if (res_valid3 !== 1'b0) begin bad++; $display("FAIL s3_early_1: got %b want 0", res_valid3); end
    step();
    total++; if (res_valid3 !== 1'b0) begin bad++; $display("FAIL s3_early_2: got %b want 0", res_valid3); end
    step();
    total++; if (res_valid3 !== 1'b1) begin bad++; $display("FAIL s3_valid_at_3: got %b want 1", res_valid3); end
    total++; if (res_y3 !== {5'b0, s, a ^ b} || res_sel3 !== s) begin bad++; $display("FAIL s3_result: got %h/%0d want %h/%0d", res_y3, res_sel3, {5'b0, s, a ^ b}, s); end
    step();
    total++; if (res_valid3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL s3_drain: got v=%b busy=%b want 0 0", res_valid3, busy3); end
  endtask

  // Transaction model: a command taken at edge t yields its result from edge
  // t+SETTLE until the first edge with res_ready high; the sequencer is free after.
  task automatic test_random();
    localparam int SETTLE1 = 1;
    int         edge_n = 0;
    bit         m_busy = 0;
    bit         m_hold = 0;
    int         m_rise = 0;
    logic [15:0] m_y = '0;
    logic [2:0]  m_sel = '0;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_sel   = 3'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #0;
      total++; if (cmd_ready !== !m_busy) begin bad++; $display("FAIL rnd_cmd_ready_%0d: got %b want %b", i, cmd_ready, !m_busy); end
      step();
      edge_n++;
      if (m_hold && res_ready) begin
        m_hold = 0;
        m_busy = 0;
      end else if (!m_busy && cmd_valid) begin
        m_busy = 1;
        m_rise = edge_n + SETTLE1;
        m_y    = {5'b0, cmd_sel, cmd_a ^ cmd_b};
        m_sel  = cmd_sel;
      end else if (m_busy && !m_hold && edge_n == m_rise) begin
        m_hold = 1;
      end
      total++; if (res_valid !== m_hold || busy !== m_busy) begin bad++; $display("FAIL rnd_flags_%0d: got v=%b busy=%b want %b %b", i, res_valid, busy, m_hold, m_busy); end
      if (m_hold) begin
        total++; if (res_y !== m_y || res_sel !== m_sel) begin bad++; $display("FAIL rnd_result_%0d: got %h/%0d want %h/%0d", i, res_y, res_sel, m_y, m_sel); end
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_sweep();
    test_simultaneous();
    test_reset_mid_sweep();
    test_settle3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
